// File: rtl/cpu_pkg.sv
// cpu_pkg: shared definitions for the SAP CPU control path.
//   - opcode values (IR high nibble)
//   - sequencer state encoding (IDLE=0, T1..T6=1..6, HALT=7)
//   - control-word field indices and a one-hot field helper
package cpu_pkg;

  localparam logic [3:0] OP_LDA = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_JMP = 4'h3;
  localparam logic [3:0] OP_JC  = 4'h4;
  localparam logic [3:0] OP_JZ  = 4'h5;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_T1   = 3'd1,
    ST_T2   = 3'd2,
    ST_T3   = 3'd3,
    ST_T4   = 3'd4,
    ST_T5   = 3'd5,
    ST_T6   = 3'd6,
    ST_HALT = 3'd7
  } state_t;

  // Control-word bit positions.
  localparam int CW_EP = 0;
  localparam int CW_C  = 1;
  localparam int CW_LP = 2;
  localparam int CW_LM = 3;
  localparam int CW_CE = 4;
  localparam int CW_LI = 5;
  localparam int CW_EI = 6;
  localparam int CW_LA = 7;
  localparam int CW_EA = 8;
  localparam int CW_LB = 9;
  localparam int CW_SU = 10;
  localparam int CW_EU = 11;
  localparam int CW_LO = 12;
  localparam int CW_W  = 13;

  typedef logic [CW_W-1:0] ctrl_word_t;

  function automatic ctrl_word_t cw_bit(input int unsigned idx);
    ctrl_word_t w;
    w      = '0;
    w[idx] = 1'b1;
    return w;
  endfunction

endpackage

// File: rtl/cpu_ctrl_decode.sv
// cpu_ctrl_decode: purely combinational control-word decode for the SAP
// sequencer.
//   state     in   current sequencer state
//   opcode    in   IR[7:4]
//   flag_c    in   ALU carry (JC, only with SAP_COND_JUMP_EN)
//   flag_z    in   ALU zero  (JZ, only with SAP_COND_JUMP_EN)
//   cw        out  control word, indexed by cpu_pkg CW_* fields
//   last_step out  this is the final execute step of the instruction
//   halt_req  out  HLT reached T4; sequencer parks in HALT
// Macro SAP_COND_JUMP_EN: when defined JC/JZ load the PC on their flag,
// otherwise they decode as NOP.
module cpu_ctrl_decode
  import cpu_pkg::*;
#(
  parameter int OPW = 4
) (
  input  state_t           state,
  input  logic [OPW-1:0]   opcode,
  input  logic             flag_c,
  input  logic             flag_z,
  output ctrl_word_t       cw,
  output logic             last_step,
  output logic             halt_req
);

`ifndef SAP_COND_JUMP_EN
  logic unused_flags;
  assign unused_flags = flag_c ^ flag_z;
`endif

  always_comb begin
    cw        = '0;
    last_step = 1'b0;
    halt_req  = 1'b0;
    case (state)
      ST_T1: cw = cw_bit(CW_EP) | cw_bit(CW_LM);
      ST_T2: cw = cw_bit(CW_C);
      ST_T3: cw = cw_bit(CW_CE) | cw_bit(CW_LI);
      ST_T4: begin
        case (opcode)
          OP_LDA, OP_ADD, OP_SUB: cw = cw_bit(CW_EI) | cw_bit(CW_LM);
          OP_JMP: begin
            cw        = cw_bit(CW_EI) | cw_bit(CW_LP);
            last_step = 1'b1;
          end
          OP_OUT: begin
            cw        = cw_bit(CW_EA) | cw_bit(CW_LO);
            last_step = 1'b1;
          end
          OP_HLT: begin
            halt_req  = 1'b1;
            last_step = 1'b1;
          end
`ifdef SAP_COND_JUMP_EN
          OP_JC: begin
            last_step = 1'b1;
            if (flag_c) cw = cw_bit(CW_EI) | cw_bit(CW_LP);
          end
          OP_JZ: begin
            last_step = 1'b1;
            if (flag_z) cw = cw_bit(CW_EI) | cw_bit(CW_LP);
          end
`endif
          default: last_step = 1'b1;
        endcase
      end
      ST_T5: begin
        case (opcode)
          OP_LDA: begin
            cw        = cw_bit(CW_CE) | cw_bit(CW_LA);
            last_step = 1'b1;
          end
          OP_ADD, OP_SUB: cw = cw_bit(CW_CE) | cw_bit(CW_LB);
          // Unreachable for other opcodes; terminate defensively.
          default: last_step = 1'b1;
        endcase
      end
      ST_T6: begin
        last_step = 1'b1;
        case (opcode)
          OP_ADD: cw = cw_bit(CW_EU) | cw_bit(CW_LA);
          OP_SUB: cw = cw_bit(CW_EU) | cw_bit(CW_LA) | cw_bit(CW_SU);
          default: cw = '0;
        endcase
      end
      default: cw = '0;
    endcase
  end

endmodule

// File: rtl/cpu_ctrl_seq.sv
// cpu_ctrl_seq: T-state control sequencer for the 4-bit SAP CPU.
// Holds the state register and next-state logic; strobes come from
// cpu_ctrl_decode.
//   clk, rst         clock; asynchronous active-low reset
//   run              start/continue (sampled in IDLE and at instruction end)
//   opcode           IR[7:4]
//   flag_c, flag_z   ALU flags for JC/JZ
//   ep c lp lm ce li ei la ea lb su eu lo   control strobes
//   halted           high while parked in HALT
//   tstate           0=IDLE, 1..6=T1..T6, 7=HALT
// Macro SAP_COND_JUMP_EN enables conditional jumps (see cpu_ctrl_decode).
module cpu_ctrl_seq
  import cpu_pkg::*;
#(
  parameter int OPW     = 4,
  parameter int T_STEPS = 6
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           run,
  input  logic [OPW-1:0] opcode,
  input  logic           flag_c,
  input  logic           flag_z,
  output logic           ep,
  output logic           c,
  output logic           lp,
  output logic           lm,
  output logic           ce,
  output logic           li,
  output logic           ei,
  output logic           la,
  output logic           ea,
  output logic           lb,
  output logic           su,
  output logic           eu,
  output logic           lo,
  output logic           halted,
  output logic [2:0]     tstate
);

  localparam state_t ST_LAST = state_t'(3'(T_STEPS));

  state_t     state_q, state_d;
  ctrl_word_t cw;
  logic       last_step;
  logic       halt_req;

  cpu_ctrl_decode #(.OPW(OPW)) u_decode (
    .state     (state_q),
    .opcode    (opcode),
    .flag_c    (flag_c),
    .flag_z    (flag_z),
    .cw        (cw),
    .last_step (last_step),
    .halt_req  (halt_req)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (run) state_d = ST_T1;
      ST_T1:   state_d = ST_T2;
      ST_T2:   state_d = ST_T3;
      ST_T3:   state_d = ST_T4;
      ST_T4, ST_T5, ST_T6: begin
        if (halt_req)
          state_d = ST_HALT;
        else if (last_step || (state_q == ST_LAST))
          state_d = run ? ST_T1 : ST_IDLE;
        else
          state_d = state_t'(3'(state_q) + 3'd1);
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_IDLE;
    endcase
  end

  assign ep     = cw[CW_EP];
  assign c      = cw[CW_C];
  assign lp     = cw[CW_LP];
  assign lm     = cw[CW_LM];
  assign ce     = cw[CW_CE];
  assign li     = cw[CW_LI];
  assign ei     = cw[CW_EI];
  assign la     = cw[CW_LA];
  assign ea     = cw[CW_EA];
  assign lb     = cw[CW_LB];
  assign su     = cw[CW_SU];
  assign eu     = cw[CW_EU];
  assign lo     = cw[CW_LO];
  assign halted = (state_q == ST_HALT);
  assign tstate = 3'(state_q);

endmodule
